// File: rtl/sonic_pkg.sv
// sonic_pkg
// Shared definitions for the ultrasonic trigger/echo ranging link. The
// scaling constants are shared with the ranging controller so that both
// ends convert between echo width and distance in the same way.
//   US_PER_CM  : echo microseconds per centimetre of target distance
//   MAX_CM     : largest distance the sensor reports
//   TIMEOUT_US : echo width used for "no object" / out of range
//   DIST_W     : width of the distance bus
//   CNT_W      : width of the microsecond tick counters
package sonic_pkg;

  localparam int unsigned US_PER_CM  = 58;
  localparam int unsigned MAX_CM     = 400;
  localparam int unsigned TIMEOUT_US = 38000;
  localparam int unsigned DIST_W     = 9;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TRIG  = 3'd1,
    S_BURST = 3'd2,
    S_ECHO  = 3'd3,
    S_HOLD  = 3'd4
  } sonic_state_e;

  // Increment that sticks at all-ones instead of wrapping, so a stuck-high
  // trigger can never alias back to a short width.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// us_tick_gen
// Microsecond time base: a one-cycle pulse every TICK_COUNT clocks.
// Asserting clear restarts the count so that the first tick after a clear
// lands exactly TICK_COUNT cycles later.
//   clk   : clock
//   reset : asynchronous, active-high
//   clear : synchronous restart of the count
//   tick  : one-cycle pulse, decoded from the count register
module us_tick_gen #(
  parameter int unsigned TICK_COUNT = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CW'(TICK_COUNT - 1));

  // Next count: restart on clear or at the end of each tick period.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CW{1'b0}};
    end else if (tick) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sonic_echo_emulator.sv
// sonic_echo_emulator
// Responder end of the trigger/echo ranging protocol. Validates the width
// of a trigger pulse, waits a fixed burst interval, then drives an echo
// pulse whose width encodes dist_cm, followed by a hold-off dead time.
//   clk      : clock (TICK_COUNT cycles per microsecond)
//   reset    : asynchronous, active-high
//   trigger  : trigger from the controller, asynchronous to clk
//   dist_cm  : target distance in cm, sampled when the trigger falls
//   echo     : echo pulse (registered)
//   busy     : high whenever a measurement or hold-off is in progress
//   trig_err : one-cycle pulse when a trigger is rejected as too short
//   done     : one-cycle pulse in the cycle echo falls
// All outputs are registered from the state register, so each output
// trails the state transition that causes it by one clock.
module sonic_echo_emulator #(
  parameter int unsigned TICK_COUNT  = 100,
  parameter int unsigned MIN_TRIG_US = 10,
  parameter int unsigned BURST_US    = 200,
  parameter int unsigned US_PER_CM   = sonic_pkg::US_PER_CM,
  parameter int unsigned MAX_CM      = sonic_pkg::MAX_CM,
  parameter int unsigned TIMEOUT_US  = sonic_pkg::TIMEOUT_US,
  parameter int unsigned HOLDOFF_US  = 10000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          trigger,
  input  logic [sonic_pkg::DIST_W-1:0]  dist_cm,
  output logic                          echo,
  output logic                          busy,
  output logic                          trig_err,
  output logic                          done
);

  import sonic_pkg::*;

  // Echo length in microseconds; out-of-range distances report the timeout.
  function automatic logic [CNT_W-1:0] calc_echo_len(input logic [DIST_W-1:0] d);
    logic [CNT_W-1:0] len;
    if ((d == {DIST_W{1'b0}}) || (32'(d) > MAX_CM)) begin
      len = CNT_W'(TIMEOUT_US);
    end else begin
      len = CNT_W'(32'(d) * US_PER_CM);
    end
    return len;
  endfunction

  logic             trig_s1_q, trig_s2_q, trig_prev_q;
  logic             trig_rise_s, trig_fall_s;
  sonic_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s, cnt_adv_s, target_s;
  logic [CNT_W-1:0] echo_len_q, echo_len_d;
  logic             err_pend_q, err_pend_d;
  logic             tick_s, tick_clear_s, phase_end_s;
  logic             echo_q, busy_q, trig_err_q, done_q;

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_s1_q   <= 1'b0;
      trig_s2_q   <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      trig_s1_q   <= trigger;
      trig_s2_q   <= trig_s1_q;
      trig_prev_q <= trig_s2_q;
    end
  end

  assign trig_rise_s = trig_s2_q & ~trig_prev_q;
  assign trig_fall_s = ~trig_s2_q & trig_prev_q;

  // The time base restarts on every state change and is held in IDLE, so
  // each phase lasts a whole number of microseconds from its entry.
  assign tick_clear_s = (state_d != state_q) || (state_q == S_IDLE);

  us_tick_gen #(
    .TICK_COUNT (TICK_COUNT)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear_s),
    .tick  (tick_s)
  );

  // Count including the tick of the current cycle: the trigger-fall cycle
  // itself may carry the tick that completes the minimum width.
  assign cnt_inc_s = sat_inc(cnt_q);
  assign cnt_adv_s = tick_s ? cnt_inc_s : cnt_q;

  // Phase length of the timed states.
  always_comb begin
    target_s = {{(CNT_W-1){1'b0}}, 1'b1};
    case (state_q)
      S_BURST: target_s = CNT_W'(BURST_US);
      S_ECHO:  target_s = echo_len_q;
      S_HOLD:  target_s = CNT_W'(HOLDOFF_US);
      default: target_s = {{(CNT_W-1){1'b0}}, 1'b1};
    endcase
  end

  assign phase_end_s = tick_s && (cnt_inc_s >= target_s);
  assign cnt_d       = tick_clear_s ? {CNT_W{1'b0}} : cnt_adv_s;

  // Next-state logic; triggers outside IDLE/TRIG are ignored, never queued.
  always_comb begin
    state_d    = state_q;
    echo_len_d = echo_len_q;
    err_pend_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig_rise_s) begin
          state_d = S_TRIG;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRIG: begin
        if (trig_fall_s) begin
          if (cnt_adv_s >= CNT_W'(MIN_TRIG_US)) begin
            echo_len_d = calc_echo_len(dist_cm);
            state_d    = S_BURST;
          end else begin
            err_pend_d = 1'b1;
            state_d    = S_IDLE;
          end
        end else begin
          state_d = S_TRIG;
        end
      end
      S_BURST: begin
        if (phase_end_s) begin
          state_d = S_ECHO;
        end else begin
          state_d = S_BURST;
        end
      end
      S_ECHO: begin
        if (phase_end_s) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_ECHO;
        end
      end
      S_HOLD: begin
        if (phase_end_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, tick counter, latched echo length and pending-error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      echo_len_q <= {CNT_W{1'b0}};
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      echo_len_q <= echo_len_d;
      err_pend_q <= err_pend_d;
    end
  end

  // Registered outputs; done marks the cycle echo drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_q     <= 1'b0;
      busy_q     <= 1'b0;
      trig_err_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      echo_q     <= (state_q == S_ECHO);
      busy_q     <= (state_q != S_IDLE);
      trig_err_q <= err_pend_q;
      done_q     <= echo_q && (state_q != S_ECHO);
    end
  end

  assign echo     = echo_q;
  assign busy     = busy_q;
  assign trig_err = trig_err_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sonic_echo_emulator.sv
// tb_sonic_echo_emulator
// Scoreboard bench: each trigger pushes its expected response (echo rise
// cycle and width, or trig_err cycle); a monitor pops and compares whenever
// the DUT presents echo fall / trig_err. Scaled-down timing parameters.
module tb_sonic_echo_emulator;

  localparam int T   = 4;
  localparam int MIN = 10;
  localparam int BUS = 20;
  localparam int UPC = 3;
  localparam int MXC = 400;
  localparam int TO  = 1500;
  localparam int HO  = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       trigger = 1'b0;
  logic [8:0] dist_cm = 9'd0;
  logic       echo, busy, trig_err, done;

  sonic_echo_emulator #(
    .TICK_COUNT (T),
    .MIN_TRIG_US(MIN),
    .BURST_US   (BUS),
    .US_PER_CM  (UPC),
    .MAX_CM     (MXC),
    .TIMEOUT_US (TO),
    .HOLDOFF_US (HO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .trigger  (trigger),
    .dist_cm  (dist_cm),
    .echo     (echo),
    .busy     (busy),
    .trig_err (trig_err),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit is_err; int at_cyc; int width; } exp_t;
  exp_t exp_q[$];

  typedef struct { int w; int d; bit acc; int ew; } vec_t;
  // width(cycles), dist, accepted, hand-computed echo width in cycles
  vec_t vecs[8] = '{
    '{48, 100, 1'b1, 1200},
    '{36, 100, 1'b0, 0},
    '{40,  50, 1'b1, 600},
    '{39,  50, 1'b0, 0},
    '{40,   0, 1'b1, 6000},
    '{40, 401, 1'b1, 6000},
    '{40, 400, 1'b1, 4800},
    '{60,   7, 1'b1, 84}
  };

  int nvec = 0;
  int nmis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor
  logic echo_prev = 1'b0;
  logic busy_prev = 1'b0;
  int   rise_cyc = -1;
  int   busy_fall_exp = -1;
  exp_t mon_e;

  always @(negedge clk) begin
    if (reset) begin
      echo_prev = 1'b0;
      busy_prev = 1'b0;
      busy_fall_exp = -1;
    end else begin
      if (echo && !echo_prev) rise_cyc = cyc;
      if (trig_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_trig_err", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("err_kind", 32'(mon_e.is_err), 32'd1);
          check("err_time", cyc, mon_e.at_cyc);
          check("err_busy_low", 32'(busy), 32'd0);
          check("err_echo_low", 32'(echo), 32'd0);
        end
      end
      if (echo_prev && !echo) begin
        check("done_on_fall", 32'(done), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_echo", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("echo_kind", 32'(mon_e.is_err), 32'd0);
          check("echo_rise", rise_cyc, mon_e.at_cyc);
          check("echo_width", cyc - rise_cyc, mon_e.width);
        end
        busy_fall_exp = cyc + HO * T;
      end else if (done) begin
        check("stray_done", 32'(done), 32'd0);
      end
      if (busy_prev && !busy && busy_fall_exp >= 0) begin
        check("busy_fall", cyc, busy_fall_exp);
        busy_fall_exp = -1;
      end
      echo_prev = echo;
      busy_prev = busy;
    end
  end

  int fall_edge;

  task automatic send(input int w, input int d, input bit acc, input int ew);
    exp_t e;
    @(negedge clk);
    dist_cm = 9'(d);
    trigger = 1'b1;
    repeat (w) @(negedge clk);
    trigger = 1'b0;
    fall_edge = cyc + 1;
    e.is_err = !acc;
    e.at_cyc = acc ? (fall_edge + 3 + BUS * T) : (fall_edge + 3);
    e.width  = ew;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (6) @(negedge clk);
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int width;
    repeat (3) @(negedge clk);
    check("reset_echo", 32'(echo), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_trig_err", 32'(trig_err), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_echo", 32'(echo), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    foreach (vecs[i]) begin
      send(vecs[i].w, vecs[i].d, vecs[i].acc, vecs[i].ew);
      wait_idle();
    end

    // Retriggers in BURST, ECHO (with dist change) and HOLD; the last one
    // is still high when IDLE is re-entered and must not start a cycle.
    send(48, 20, 1'b1, 240);
    repeat (10) @(negedge clk);
    trigger = 1'b1;
    repeat (20) @(negedge clk);
    trigger = 1'b0;
    repeat (120) @(negedge clk);
    dist_cm = 9'd300;
    trigger = 1'b1;
    repeat (48) @(negedge clk);
    trigger = 1'b0;
    repeat (142) @(negedge clk);
    trigger = 1'b1;
    repeat (121) @(negedge clk);
    trigger = 1'b0;
    wait_idle();
    send(48, 33, 1'b1, 396);
    wait_idle();

    // Reset in the middle of ECHO.
    send(48, 100, 1'b1, 1200);
    n = 0;
    while (!echo && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reset_test_echo_seen", 32'(echo), 32'd1);
    repeat (100) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midecho_reset_echo", 32'(echo), 32'd0);
    check("midecho_reset_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("post_reset_echo", 32'(echo), 32'd0);
    check("post_reset_busy", 32'(busy), 32'd0);

    // Closed loop: controller-side measurement of the echo width.
    send(48, 100, 1'b1, 1200);
    n = 0;
    while (!echo && n < 2000) begin
      @(negedge clk);
      n++;
    end
    width = 0;
    while (echo && width < 10000) begin
      @(negedge clk);
      width++;
    end
    check("closed_loop_cm", width / (T * UPC), 32'd100);
    wait_idle();

    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
